join_timeout_watchdog: RTL and testbench
========================================

// Module: join_timeout_watchdog
// PURPOSE
//  Synthesisable, parametrised join/timeout controller for N_CH concurrent transaction channels.
//  - Arms a set of channels and waits for them in JOIN_ANY or JOIN_ALL mode, with a runtime timeout.
//  - On join, timeout or abort: pulses ch_kill_o for still-pending channels, then reports status.
//  - Sits between a transaction scheduler and per-channel engines; kill drives engine flush.
// PARAMETERS
//  N_CH   4  number of transaction channels (1..32)
//  CNT_W  16 timeout counter width; max timeout = 2**CNT_W-1 cycles
// PORTS
//  clk          in   1          clock, all logic rising-edge
//  rst_n        in   1          asynchronous active-low reset
//  start_i      in   1          arm request, sampled in IDLE only
//  start_mask_i in   N_CH       channels to wait on, latched on accepted start
//  join_mode_i  in   1          0 = JOIN_ALL, 1 = JOIN_ANY; latched on accepted start
//  timeout_i    in   CNT_W      timeout in cycles; 0 = no timeout; latched on accepted start
//  abort_i      in   1          software disable of the whole group while busy
//  ch_done_i    in   N_CH       per-channel completion pulse
//  busy_o       out  1          high while armed
//  done_o       out  1          1-cycle pulse: group finished (any cause)
//  status_o     out  2          valid with done_o: 0 = OK, 1 = TIMEOUT, 2 = ABORT
//  done_mask_o  out  N_CH       channels that completed; held until next accepted start
//  winner_o     out  $clog2(N_CH) lowest-index channel completing on the join edge; held
//  ch_kill_o    out  N_CH       1-cycle pulse on channels still pending at termination
//  start_err_o  out  1          1-cycle pulse: start_i while busy, or start with zero mask
// BEHAVIOUR
//  Reset
//  - All outputs 0; FSM = IDLE; pending, completed and counter cleared.
//  - Reset mid-operation discards the group: no kill, no done pulse.
//  FSM states: IDLE, RUN. All outputs registered.
//  IDLE -> RUN
//  - On start_i with start_mask_i != 0.
//  - Latches pending = mask, mode, cnt = timeout_i; clears done_mask_o; busy_o = 1 next cycle.
//  - ch_done_i on the start edge is ignored.
//  RUN, evaluated each edge
//  - hits = ch_done_i & pending; pending &= ~hits; done_mask_o |= hits.
//  - Non-pending or unarmed ch_done_i are ignored.
//  - Join met: ANY -> hits != 0; ALL -> pending becomes 0 on this edge.
//  - Timeout: if timeout != 0, cnt decrements every RUN edge; expires on the edge where cnt == 1
//    (the T-th RUN edge) and join is not met.
//  Termination edge
//  - Precedence: abort_i > join > timeout.
//  - Outputs: done_o = 1; status_o set; ch_kill_o = pending after this edge's hits; busy_o = 0;
//    FSM -> IDLE.
//  - JOIN_ALL OK: ch_kill_o = 0.
//  - winner_o updates only on OK termination; ABORT and TIMEOUT leave it unchanged.
//  Simultaneous events
//  - Join on the same edge as expiry -> OK, not TIMEOUT.
//  - Abort on the same edge as a hit -> ABORT; the hit is still recorded in done_mask_o.
//  Starts
//  - start_i while busy (including the termination edge) is ignored and start_err_o pulses.
//  - A start is accepted the cycle after done_o.
//  - start_i with zero mask in IDLE -> start_err_o, stays IDLE.
//  Width rules
//  - cnt is an unsigned CNT_W down-counter; it never wraps below 1.
//  - With timeout 0, cnt is frozen.
// STRUCTURE
//  - Package jtw_pkg:
//    - join_mode_e {JOIN_ALL, JOIN_ANY}
//    - status_e {ST_OK, ST_TIMEOUT, ST_ABORT}
//    - fsm_e {IDLE, RUN}
//  - Sub-module jtw_timeout_ctr (load / en / expire, CNT_W wide) holds the down-counter.
//  - Lowest-set-bit priority encoder stays inline as a function.
// TESTING (N_CH = 4, CNT_W = 8)
//  1. ANY: start mask 4'b0110, T = 20; ch_done[2] at RUN cycle 5 -> done_o, OK, winner = 2,
//     done_mask = 0100, ch_kill = 0010.
//  2. ALL: mask 1011, T = 50; dones ch0 @3, ch3 @7, ch1 @9 -> done at edge 9, OK,
//     done_mask = 1011, kill = 0000.
//  3. Timeout: mask 0011, ALL, T = 10; only ch0 completes -> done on 10th RUN edge, TIMEOUT,
//     done_mask = 0001, kill = 0010.
//  4. Collisions: ANY, T = 6, ch_done[1] on the 6th RUN edge -> OK, not TIMEOUT.
//     Also abort_i together with ch_done[0] -> ABORT, done_mask = 0001, kill = remaining mask.
//  5. Misuse: start while busy, and start with mask 0 -> start_err_o pulses, state unchanged.
//     T = 0 with no dones for 1000 cycles -> still busy.
//  6. Reset: assert rst_n low mid-RUN -> all outputs 0 asynchronously, no kill/done.
//     A new start after release works.

Source files
------------

// File: rtl/join_timeout_watchdog_pkg.sv
// Shared types for the join/timeout watchdog: join mode, termination status and FSM state.
package jtw_pkg;

    typedef enum logic {
        JOIN_ALL = 1'b0,
        JOIN_ANY = 1'b1
    } join_mode_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_TIMEOUT = 2'd1,
        ST_ABORT   = 2'd2
    } status_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_e;

endpackage

// File: rtl/join_timeout_watchdog_if.sv
// Scheduler-facing bundle of the join/timeout watchdog; master = scheduler, slave = watchdog.
interface join_timeout_watchdog_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned WIN_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic              start_i;
    logic [N_CH-1:0]   start_mask_i;
    logic              join_mode_i;
    logic [CNT_W-1:0]  timeout_i;
    logic              abort_i;
    logic [N_CH-1:0]   ch_done_i;
    logic              busy_o;
    logic              done_o;
    logic [1:0]        status_o;
    logic [N_CH-1:0]   done_mask_o;
    logic [WIN_W-1:0]  winner_o;
    logic [N_CH-1:0]   ch_kill_o;
    logic              start_err_o;

    modport master (
        output start_i, start_mask_i, join_mode_i, timeout_i, abort_i, ch_done_i,
        input  busy_o, done_o, status_o, done_mask_o, winner_o, ch_kill_o, start_err_o
    );

    modport slave (
        input  start_i, start_mask_i, join_mode_i, timeout_i, abort_i, ch_done_i,
        output busy_o, done_o, status_o, done_mask_o, winner_o, ch_kill_o, start_err_o
    );

endinterface

// File: rtl/join_timeout_watchdog_timeout_ctr.sv
// Timeout down-counter: loads the programmed timeout, counts down while running, flags the last cycle.
module jtw_timeout_ctr #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             expire_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A loaded value of 0 never reaches 1, so the counter stays frozen and never expires.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q > CNT_W'(1))) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign expire_c = en_i && (cnt_q == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/join_timeout_watchdog.sv
// Join/timeout controller: arms a channel group, waits for ANY/ALL completion or timeout,
// kills still-pending channels on termination and reports status.
module join_timeout_watchdog
    import jtw_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    join_timeout_watchdog_if.slave  bus
);

    localparam int unsigned WIN_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    fsm_e             state_q,     state_d;
    join_mode_e       mode_q,      mode_d;
    status_e          status_q,    status_d;
    logic [N_CH-1:0]  pending_q,   pending_d;
    logic [N_CH-1:0]  done_mask_q, done_mask_d;
    logic [N_CH-1:0]  kill_q,      kill_d;
    logic [WIN_W-1:0] winner_q,    winner_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic             start_err_q, start_err_d;

    logic             ctr_load_c;
    logic             ctr_en_c;
    logic             expire_c;
    logic [N_CH-1:0]  hits_c;
    logic [N_CH-1:0]  pend_nx_c;
    logic             join_met_c;
    logic             term_c;

    function automatic logic [WIN_W-1:0] lsb_idx(input logic [N_CH-1:0] v);
        lsb_idx = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (v[i]) lsb_idx = WIN_W'(i);
        end
    endfunction

    jtw_timeout_ctr #(.CNT_W(CNT_W)) u_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (ctr_load_c),
        .load_val_i (bus.timeout_i),
        .en_i       (ctr_en_c),
        .expire_c   (expire_c)
    );

    // Next-state and output logic; precedence on termination is abort > join > timeout.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        status_d    = status_q;
        pending_d   = pending_q;
        done_mask_d = done_mask_q;
        winner_d    = winner_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        kill_d      = '0;
        start_err_d = 1'b0;
        ctr_load_c  = 1'b0;
        ctr_en_c    = 1'b0;
        term_c      = 1'b0;
        hits_c      = bus.ch_done_i & pending_q;
        pend_nx_c   = pending_q & ~hits_c;
        join_met_c  = (mode_q == JOIN_ANY) ? (hits_c != '0) : (pend_nx_c == '0);

        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    if (bus.start_mask_i != '0) begin
                        state_d     = RUN;
                        pending_d   = bus.start_mask_i;
                        mode_d      = join_mode_e'(bus.join_mode_i);
                        done_mask_d = '0;
                        busy_d      = 1'b1;
                        ctr_load_c  = 1'b1;
                    end else begin
                        start_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                ctr_en_c    = 1'b1;
                pending_d   = pend_nx_c;
                done_mask_d = done_mask_q | hits_c;
                start_err_d = bus.start_i;
                if (bus.abort_i) begin
                    term_c   = 1'b1;
                    status_d = ST_ABORT;
                end else if (join_met_c) begin
                    term_c   = 1'b1;
                    status_d = ST_OK;
                    winner_d = lsb_idx(hits_c);
                end else if (expire_c) begin
                    term_c   = 1'b1;
                    status_d = ST_TIMEOUT;
                end
                if (term_c) begin
                    state_d   = IDLE;
                    pending_d = '0;
                    kill_d    = pend_nx_c;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= JOIN_ALL;
            status_q    <= ST_OK;
            pending_q   <= '0;
            done_mask_q <= '0;
            kill_q      <= '0;
            winner_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            status_q    <= status_d;
            pending_q   <= pending_d;
            done_mask_q <= done_mask_d;
            kill_q      <= kill_d;
            winner_q    <= winner_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            start_err_q <= start_err_d;
        end
    end

    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.status_o    = status_q;
    assign bus.done_mask_o = done_mask_q;
    assign bus.winner_o    = winner_q;
    assign bus.ch_kill_o   = kill_q;
    assign bus.start_err_o = start_err_q;

endmodule

// File: tb/tb_join_timeout_watchdog.sv
// Directed bench for join_timeout_watchdog (N_CH=4, CNT_W=8) with immediate-assertion checks.
module tb_join_timeout_watchdog;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    join_timeout_watchdog_if #(.N_CH(4), .CNT_W(8)) bus ();

    join_timeout_watchdog #(.N_CH(4), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic arm(input logic [3:0] mask, input logic mode, input logic [7:0] tmo);
        bus.start_i      = 1'b1;
        bus.start_mask_i = mask;
        bus.join_mode_i  = mode;
        bus.timeout_i    = tmo;
        tick(1);
        bus.start_i      = 1'b0;
        bus.start_mask_i = '0;
    endtask

    task automatic pulse_done(input logic [3:0] d);
        bus.ch_done_i = d;
        tick(1);
        bus.ch_done_i = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.start_i      = 1'b0;
        bus.start_mask_i = '0;
        bus.join_mode_i  = 1'b0;
        bus.timeout_i    = '0;
        bus.abort_i      = 1'b0;
        bus.ch_done_i    = '0;
        tick(2);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_done", 32'(bus.done_o), 32'd0);
        chk("rst_mask", 32'(bus.done_mask_o), 32'd0);
        chk("rst_kill", 32'(bus.ch_kill_o), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // 1: ANY, ch2 completes on RUN edge 5
        arm(4'b0110, 1'b1, 8'd20);
        chk("t1_busy", 32'(bus.busy_o), 32'd1);
        tick(4);
        chk("t1_wait", 32'(bus.done_o), 32'd0);
        pulse_done(4'b0100);
        chk("t1_done",   32'(bus.done_o), 32'd1);
        chk("t1_status", 32'(bus.status_o), 32'd0);
        chk("t1_winner", 32'(bus.winner_o), 32'd2);
        chk("t1_dmask",  32'(bus.done_mask_o), 32'b0100);
        chk("t1_kill",   32'(bus.ch_kill_o), 32'b0010);
        chk("t1_busy0",  32'(bus.busy_o), 32'd0);
        tick(1);
        chk("t1_done_pulse", 32'(bus.done_o), 32'd0);
        chk("t1_kill_pulse", 32'(bus.ch_kill_o), 32'd0);
        chk("t1_dmask_hold", 32'(bus.done_mask_o), 32'b0100);

        // 2: ALL, ch0@3 ch3@7 ch1@9
        arm(4'b1011, 1'b0, 8'd50);
        chk("t2_dmask_clr", 32'(bus.done_mask_o), 32'd0);
        tick(2);
        pulse_done(4'b0001);
        chk("t2_e3_done",  32'(bus.done_o), 32'd0);
        chk("t2_e3_dmask", 32'(bus.done_mask_o), 32'b0001);
        tick(3);
        pulse_done(4'b1000);
        chk("t2_e7_done", 32'(bus.done_o), 32'd0);
        tick(1);
        pulse_done(4'b0010);
        chk("t2_done",   32'(bus.done_o), 32'd1);
        chk("t2_status", 32'(bus.status_o), 32'd0);
        chk("t2_dmask",  32'(bus.done_mask_o), 32'b1011);
        chk("t2_kill",   32'(bus.ch_kill_o), 32'd0);
        chk("t2_winner", 32'(bus.winner_o), 32'd1);
        tick(1);

        // 3: ALL timeout T=10, only ch0 completes
        arm(4'b0011, 1'b0, 8'd10);
        tick(1);
        pulse_done(4'b0001);
        tick(7);
        chk("t3_e9_done", 32'(bus.done_o), 32'd0);
        tick(1);
        chk("t3_done",   32'(bus.done_o), 32'd1);
        chk("t3_status", 32'(bus.status_o), 32'd1);
        chk("t3_dmask",  32'(bus.done_mask_o), 32'b0001);
        chk("t3_kill",   32'(bus.ch_kill_o), 32'b0010);
        chk("t3_winner", 32'(bus.winner_o), 32'd1);
        tick(1);

        // 4a: ANY T=6, ch1 hit on the expiry edge -> OK
        arm(4'b0011, 1'b1, 8'd6);
        tick(5);
        chk("t4a_wait", 32'(bus.done_o), 32'd0);
        pulse_done(4'b0010);
        chk("t4a_done",   32'(bus.done_o), 32'd1);
        chk("t4a_status", 32'(bus.status_o), 32'd0);
        chk("t4a_kill",   32'(bus.ch_kill_o), 32'b0001);
        tick(1);

        // 4b: abort together with a ch0 hit -> ABORT, hit still recorded
        arm(4'b0111, 1'b1, 8'd30);
        tick(2);
        bus.abort_i = 1'b1;
        pulse_done(4'b0001);
        bus.abort_i = 1'b0;
        chk("t4b_done",   32'(bus.done_o), 32'd1);
        chk("t4b_status", 32'(bus.status_o), 32'd2);
        chk("t4b_dmask",  32'(bus.done_mask_o), 32'b0001);
        chk("t4b_kill",   32'(bus.ch_kill_o), 32'b0110);
        chk("t4b_winner", 32'(bus.winner_o), 32'd1);
        tick(1);

        // 5: misuse
        arm(4'b0000, 1'b0, 8'd5);
        chk("t5_zero_err",  32'(bus.start_err_o), 32'd1);
        chk("t5_zero_busy", 32'(bus.busy_o), 32'd0);
        tick(1);
        chk("t5_err_pulse", 32'(bus.start_err_o), 32'd0);
        arm(4'b0001, 1'b0, 8'd0);
        chk("t5_busy", 32'(bus.busy_o), 32'd1);
        arm(4'b0010, 1'b1, 8'd3);
        chk("t5_busy_err", 32'(bus.start_err_o), 32'd1);
        chk("t5_busy_keep", 32'(bus.busy_o), 32'd1);
        tick(1000);
        chk("t5_t0_busy", 32'(bus.busy_o), 32'd1);
        chk("t5_t0_done", 32'(bus.done_o), 32'd0);
        bus.start_i = 1'b1;
        bus.start_mask_i = 4'b0010;
        pulse_done(4'b0001);
        bus.start_i = 1'b0;
        bus.start_mask_i = '0;
        chk("t5_term_done", 32'(bus.done_o), 32'd1);
        chk("t5_term_err",  32'(bus.start_err_o), 32'd1);
        chk("t5_term_busy", 32'(bus.busy_o), 32'd0);
        arm(4'b0011, 1'b0, 8'd100);
        chk("t5_restart", 32'(bus.busy_o), 32'd1);

        // 6: asynchronous reset mid-RUN
        pulse_done(4'b0001);
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_busy",   32'(bus.busy_o), 32'd0);
        chk("t6_dmask",  32'(bus.done_mask_o), 32'd0);
        chk("t6_winner", 32'(bus.winner_o), 32'd0);
        chk("t6_status", 32'(bus.status_o), 32'd0);
        tick(2);
        chk("t6_done", 32'(bus.done_o), 32'd0);
        chk("t6_kill", 32'(bus.ch_kill_o), 32'd0);
        rst_n = 1'b1;
        tick(1);
        arm(4'b0100, 1'b1, 8'd5);
        chk("t6_rearm", 32'(bus.busy_o), 32'd1);
        pulse_done(4'b0100);
        chk("t6_post_done",   32'(bus.done_o), 32'd1);
        chk("t6_post_status", 32'(bus.status_o), 32'd0);
        chk("t6_post_winner", 32'(bus.winner_o), 32'd2);
        chk("t6_post_kill",   32'(bus.ch_kill_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
